// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the common-data-bus arbiter: ROB tag width,
// idle tag encoding, source encoding and the round-robin pick.
package cdb_arbiter_pkg;

  localparam int ROB_SIZE_WIDTH = 4;
  localparam int CDB_TAG_W      = ROB_SIZE_WIDTH + 1;
  localparam logic [CDB_TAG_W-1:0] CDB_IDLE_TAG = '1;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } cdb_src_e;

  // Winner among requesting sources; on a tie the source that did not win last goes.
  function automatic cdb_src_e rr_pick(input logic alu_req, input logic mem_req,
                                       input cdb_src_e last);
    if (alu_req && mem_req) return (last == SRC_ALU) ? SRC_MEM : SRC_ALU;
    if (mem_req)            return SRC_MEM;
    return SRC_ALU;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small per-source result FIFO feeding the CDB arbiter. Frozen while rdy is low;
// flush empties it. Storage is not reset, only pointers and count.
module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push = rdy && !flush && push;
  assign do_pop  = rdy && !flush && pop && !empty;
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (rdy) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered CDB between the ALU and load unit.
// Optional macro CDB_BYPASS_EN writes a push straight to the CDB when both FIFOs are empty.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = CDB_TAG_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             need_flush_in,
  input  logic             alu_valid,
  input  logic [31:0]      alu_value,
  input  logic [TAG_W-1:0] alu_tag,
  output logic             alu_ready,
  input  logic             mem_valid,
  input  logic [31:0]      mem_value,
  input  logic [TAG_W-1:0] mem_tag,
  output logic             mem_ready,
  output logic             cdb_valid,
  output logic [31:0]      cdb_value,
  output logic [TAG_W-1:0] cdb_tag,
  output logic             cdb_src
);

  localparam int ENTRY_W = 32 + TAG_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TAG_W-1:0] IDLE_TAG = '1;

  logic [ENTRY_W-1:0] alu_head_p0, mem_head_p0;
  logic               alu_empty, mem_empty;
  logic [CNT_W-1:0]   alu_count, mem_count;
  logic               active, alu_push, mem_push, alu_byp, mem_byp;
  logic               alu_pop, mem_pop, grant_vld;
  cdb_src_e           grant_src, rr_last;

  logic               cdb_valid_p1;
  logic [31:0]        cdb_value_p1;
  logic [TAG_W-1:0]   cdb_tag_p1;
  cdb_src_e           cdb_src_p1;

  // Ready looks only at registered counts, so a full FIFO refuses even when popping.
  assign active    = rdy_in && !need_flush_in;
  assign alu_ready = active && (alu_count < CNT_W'(FIFO_DEPTH));
  assign mem_ready = active && (mem_count < CNT_W'(FIFO_DEPTH));

`ifdef CDB_BYPASS_EN
  logic both_empty, alu_offer, mem_offer;
  assign both_empty = alu_empty && mem_empty;
  assign alu_offer  = alu_valid && alu_ready;
  assign mem_offer  = mem_valid && mem_ready;
  assign alu_byp    = both_empty && alu_offer && (!mem_offer || rr_last == SRC_MEM);
  assign mem_byp    = both_empty && mem_offer && (!alu_offer || rr_last == SRC_ALU);
`else
  assign alu_byp = 1'b0;
  assign mem_byp = 1'b0;
`endif

  assign alu_push = alu_valid && alu_ready && !alu_byp;
  assign mem_push = mem_valid && mem_ready && !mem_byp;

  always_comb begin
    grant_vld = !alu_empty || !mem_empty;
    grant_src = rr_pick(!alu_empty, !mem_empty, rr_last);
  end

  assign alu_pop = active && grant_vld && (grant_src == SRC_ALU);
  assign mem_pop = active && grant_vld && (grant_src == SRC_MEM);

  // Stage p0: per-source FIFO heads
  cdb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_alu_fifo (
    .clk_in(clk_in), .rst_in(rst_in), .rdy(rdy_in), .flush(need_flush_in),
    .push(alu_push), .push_data({alu_value, alu_tag}), .pop(alu_pop),
    .head(alu_head_p0), .empty(alu_empty), .count(alu_count)
  );

  cdb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_mem_fifo (
    .clk_in(clk_in), .rst_in(rst_in), .rdy(rdy_in), .flush(need_flush_in),
    .push(mem_push), .push_data({mem_value, mem_tag}), .pop(mem_pop),
    .head(mem_head_p0), .empty(mem_empty), .count(mem_count)
  );

  // Stage p1: registered CDB broadcast
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cdb_valid_p1 <= 1'b0;
      cdb_value_p1 <= '0;
      cdb_tag_p1   <= IDLE_TAG;
      cdb_src_p1   <= SRC_ALU;
      rr_last      <= SRC_MEM;
    end else if (rdy_in) begin
      if (need_flush_in) begin
        cdb_valid_p1 <= 1'b0;
        cdb_tag_p1   <= IDLE_TAG;
      end else if (grant_vld) begin
        cdb_valid_p1 <= 1'b1;
        {cdb_value_p1, cdb_tag_p1} <= (grant_src == SRC_ALU) ? alu_head_p0 : mem_head_p0;
        cdb_src_p1   <= grant_src;
        rr_last      <= grant_src;
      end else if (alu_byp) begin
        cdb_valid_p1 <= 1'b1;
        cdb_value_p1 <= alu_value;
        cdb_tag_p1   <= alu_tag;
        cdb_src_p1   <= SRC_ALU;
        rr_last      <= SRC_ALU;
      end else if (mem_byp) begin
        cdb_valid_p1 <= 1'b1;
        cdb_value_p1 <= mem_value;
        cdb_tag_p1   <= mem_tag;
        cdb_src_p1   <= SRC_MEM;
        rr_last      <= SRC_MEM;
      end else begin
        cdb_valid_p1 <= 1'b0;
        cdb_tag_p1   <= IDLE_TAG;
      end
    end
  end

  assign cdb_valid = cdb_valid_p1;
  assign cdb_value = cdb_value_p1;
  assign cdb_tag   = cdb_tag_p1;
  assign cdb_src   = cdb_src_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a per-source scoreboard of accepted results.
module tb_cdb_arbiter;

  localparam int TAG_W = 5;
  localparam int DEPTH = 2;

  logic             clk_in = 1'b0;
  logic             rst_in, rdy_in, need_flush_in;
  logic             alu_valid, mem_valid;
  logic [31:0]      alu_value, mem_value;
  logic [TAG_W-1:0] alu_tag, mem_tag;
  logic             alu_ready, mem_ready;
  logic             cdb_valid, cdb_src;
  logic [31:0]      cdb_value;
  logic [TAG_W-1:0] cdb_tag;

  int compared = 0;
  int mismatched = 0;

  logic [36:0]      alu_q[$];
  logic [36:0]      mem_q[$];
  logic [TAG_W-1:0] log_tag[$];
  logic             log_src[$];

  always #5 clk_in = ~clk_in;

  cdb_arbiter #(.FIFO_DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .need_flush_in(need_flush_in),
    .alu_valid(alu_valid), .alu_value(alu_value), .alu_tag(alu_tag), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_value(mem_value), .mem_tag(mem_tag), .mem_ready(mem_ready),
    .cdb_valid(cdb_valid), .cdb_value(cdb_value), .cdb_tag(cdb_tag), .cdb_src(cdb_src)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare broadcasts, then record accepted pushes, then apply flush.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      alu_q.delete();
      mem_q.delete();
    end else if (rdy_in) begin
      if (cdb_valid) begin
        log_tag.push_back(cdb_tag);
        log_src.push_back(cdb_src);
        if (cdb_src == 1'b0) begin
          check("alu_expected_pending", 64'(alu_q.size() != 0), 64'd1);
          if (alu_q.size() != 0) check("alu_bcast", 64'({cdb_value, cdb_tag}), 64'(alu_q.pop_front()));
        end else begin
          check("mem_expected_pending", 64'(mem_q.size() != 0), 64'd1);
          if (mem_q.size() != 0) check("mem_bcast", 64'({cdb_value, cdb_tag}), 64'(mem_q.pop_front()));
        end
      end
      if (alu_valid && alu_ready) alu_q.push_back({alu_value, alu_tag});
      if (mem_valid && mem_ready) mem_q.push_back({mem_value, mem_tag});
      if (need_flush_in) begin
        alu_q.delete();
        mem_q.delete();
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
  endtask

  initial begin
    logic [TAG_W-1:0] exp_tags[4];
    logic             exp_src[4];
    logic             saw_alu_low, snap_valid, snap_src;
    logic [31:0]      snap_value;
    logic [TAG_W-1:0] snap_tag;
    logic [2:0]       snap_ac, snap_mc;
    int               a_seq, m_seq;

    exp_tags = '{5'd1, 5'd8, 5'd2, 5'd9};
    exp_src  = '{1'b0, 1'b1, 1'b0, 1'b1};
    rst_in = 1'b0; rdy_in = 1'b1; need_flush_in = 1'b0;
    alu_valid = 1'b0; alu_value = '0; alu_tag = '0;
    mem_valid = 1'b0; mem_value = '0; mem_tag = '0;

    // Reset
    repeat (3) tick();
    check("rst_hold_valid", 64'(cdb_valid), 64'd0);
    check("rst_hold_tag", 64'(cdb_tag), 64'h1F);
    rst_in = 1'b1;
    #1;
    check("rst_valid", 64'(cdb_valid), 64'd0);
    check("rst_value", 64'(cdb_value), 64'd0);
    check("rst_tag", 64'(cdb_tag), 64'h1F);
    check("rst_src", 64'(cdb_src), 64'd0);
    check("rst_alu_ready", 64'(alu_ready), 64'd1);
    check("rst_mem_ready", 64'(mem_ready), 64'd1);

    // Single ALU result
    alu_valid = 1'b1; alu_value = 32'h1234; alu_tag = 5'd3;
    tick();
    alu_valid = 1'b0;
`ifdef CDB_BYPASS_EN
    check("single_c1_valid", 64'(cdb_valid), 64'd1);
    check("single_c1_value", 64'(cdb_value), 64'h1234);
    check("single_c1_tag", 64'(cdb_tag), 64'd3);
    check("single_c1_src", 64'(cdb_src), 64'd0);
    tick();
`else
    check("single_c1_valid", 64'(cdb_valid), 64'd0);
    tick();
    check("single_c2_valid", 64'(cdb_valid), 64'd1);
    check("single_c2_value", 64'(cdb_value), 64'h1234);
    check("single_c2_tag", 64'(cdb_tag), 64'd3);
    check("single_c2_src", 64'(cdb_src), 64'd0);
    tick();
`endif
    check("single_after_valid", 64'(cdb_valid), 64'd0);
    check("single_after_tag", 64'(cdb_tag), 64'h1F);
    check("single_after_value_hold", 64'(cdb_value), 64'h1234);
    repeat (2) tick();

    // Contention: ALU 1,2 and mem 8,9
    do_reset();
    log_tag.delete();
    log_src.delete();
    alu_valid = 1'b1; alu_value = 32'hA001; alu_tag = 5'd1;
    mem_valid = 1'b1; mem_value = 32'hB008; mem_tag = 5'd8;
    tick();
    alu_value = 32'hA002; alu_tag = 5'd2;
    mem_value = 32'hB009; mem_tag = 5'd9;
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    repeat (6) tick();
    check("contention_count", 64'(log_tag.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_tag.size()) begin
        check("contention_tag", 64'(log_tag[i]), 64'(exp_tags[i]));
        check("contention_src", 64'(log_src[i]), 64'(exp_src[i]));
      end
    end

    // Backpressure: both sources stream, CDB drains at one per cycle
    saw_alu_low = 1'b0; a_seq = 0; m_seq = 0;
    for (int c = 0; c < 16; c++) begin
      alu_valid = 1'b1; alu_value = 32'hC000_0000 | 32'(a_seq); alu_tag = TAG_W'(a_seq);
      mem_valid = 1'b1; mem_value = 32'hD000_0000 | 32'(m_seq); mem_tag = TAG_W'(m_seq + 16);
      if (!alu_ready) saw_alu_low = 1'b1;
      if (alu_ready) a_seq++;
      if (mem_ready) m_seq++;
      tick();
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    repeat (8) tick();
    check("bp_alu_ready_dropped", 64'(saw_alu_low), 64'd1);
    check("bp_alu_drained", 64'(alu_q.size()), 64'd0);
    check("bp_mem_drained", 64'(mem_q.size()), 64'd0);

    // Flush with entries queued
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1'b1; alu_value = 32'hE000_0000 | 32'(c); alu_tag = TAG_W'(c + 4);
      mem_valid = 1'b1; mem_value = 32'hF000_0000 | 32'(c); mem_tag = TAG_W'(c + 12);
      tick();
    end
    mem_valid = 1'b0;
    alu_valid = 1'b1; alu_value = 32'h7777; alu_tag = 5'd7;
    need_flush_in = 1'b1;
    #1;
    check("flush_queued", 64'((dut.u_alu_fifo.count != 0) || (dut.u_mem_fifo.count != 0)), 64'd1);
    check("flush_alu_ready", 64'(alu_ready), 64'd0);
    check("flush_mem_ready", 64'(mem_ready), 64'd0);
    tick();
    need_flush_in = 1'b0; alu_valid = 1'b0;
    check("flush_alu_empty", 64'(dut.u_alu_fifo.empty), 64'd1);
    check("flush_mem_empty", 64'(dut.u_mem_fifo.empty), 64'd1);
    check("flush_tag_idle", 64'(cdb_tag), 64'h1F);
    for (int c = 0; c < 4; c++) begin
      check("flush_no_valid", 64'(cdb_valid), 64'd0);
      tick();
    end

    // Stall with entries queued
    for (int c = 0; c < 2; c++) begin
      alu_valid = 1'b1; alu_value = 32'h5A00 | 32'(c); alu_tag = TAG_W'(c + 2);
      mem_valid = 1'b1; mem_value = 32'h5B00 | 32'(c); mem_tag = TAG_W'(c + 10);
      tick();
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    rdy_in = 1'b0;
    snap_valid = cdb_valid; snap_value = cdb_value; snap_tag = cdb_tag; snap_src = cdb_src;
    snap_ac = dut.u_alu_fifo.count; snap_mc = dut.u_mem_fifo.count;
    check("stall_entry_valid", 64'(snap_valid), 64'd1);
    #1;
    check("stall_alu_ready", 64'(alu_ready), 64'd0);
    check("stall_mem_ready", 64'(mem_ready), 64'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("stall_valid", 64'(cdb_valid), 64'(snap_valid));
      check("stall_value", 64'(cdb_value), 64'(snap_value));
      check("stall_tag", 64'(cdb_tag), 64'(snap_tag));
      check("stall_src", 64'(cdb_src), 64'(snap_src));
      check("stall_alu_count", 64'(dut.u_alu_fifo.count), 64'(snap_ac));
      check("stall_mem_count", 64'(dut.u_mem_fifo.count), 64'(snap_mc));
    end
    rdy_in = 1'b1;
    repeat (8) tick();
    check("final_alu_drained", 64'(alu_q.size()), 64'd0);
    check("final_mem_drained", 64'(mem_q.size()), 64'd0);
    check("final_idle_valid", 64'(cdb_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
